// File: rtl/uart_seq_checker.sv
// uart_seq_checker: locks onto a predictable UART word stream and counts
// words, parity errors and sequence errors once lock is held.
module uart_seq_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  parity_err_in,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic                  clear_counts,
    output logic                  locked,
    output logic                  error_pulse,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  parity_count,
    output logic [DATA_WIDTH-1:0] last_bad
);

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [7:0]            good_run_q, good_run_d;
    logic [7:0]            bad_run_q, bad_run_d;
    logic [1:0]            mode_q;
    logic                  locked_q, locked_d;
    logic                  error_pulse_q, error_pulse_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [CNT_WIDTH-1:0]  error_count_q, error_count_d;
    logic [CNT_WIDTH-1:0]  parity_count_q, parity_count_d;
    logic [DATA_WIDTH-1:0] last_bad_q, last_bad_d;

    logic mode_chg;
    logic check_en;
    logic match;
    logic bad;
    logic err_evt;

    function automatic logic [DATA_WIDTH-1:0] nxt(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] d,
        input logic [DATA_WIDTH-1:0] p
    );
        logic [DATA_WIDTH-1:0] r;
        unique case (m)
            2'd0:    r = d + 1'b1;
            2'd1:    r = d - 1'b1;
            2'd2:    r = p;
            default: r = ~d;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

    // A mode switch discards the word seen in the same cycle.
    assign mode_chg = (mode != mode_q);
    assign check_en = data_valid && !mode_chg;
    assign match    = (data_in == expected_q) && !parity_err_in;
    assign bad      = !match;
    assign err_evt  = check_en && (state_q == LOCKED) && bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEEK;
            expected_q     <= '0;
            good_run_q     <= '0;
            bad_run_q      <= '0;
            mode_q         <= 2'd0;
            locked_q       <= 1'b0;
            error_pulse_q  <= 1'b0;
            word_count_q   <= '0;
            error_count_q  <= '0;
            parity_count_q <= '0;
            last_bad_q     <= '0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            good_run_q     <= good_run_d;
            bad_run_q      <= bad_run_d;
            mode_q         <= mode;
            locked_q       <= locked_d;
            error_pulse_q  <= error_pulse_d;
            word_count_q   <= word_count_d;
            error_count_q  <= error_count_d;
            parity_count_q <= parity_count_d;
            last_bad_q     <= last_bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_chg) begin
            state_d = SEEK;
        end else if (data_valid) begin
            unique case (state_q)
                SEEK: begin
                    if (!parity_err_in) state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match && (good_run_q + 8'd1 == LOCK_N))
                        state_d = LOCKED;
                end
                LOCKED: begin
                    if (bad && (bad_run_q + 8'd1 == UNLOCK_N))
                        state_d = SEEK;
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_comb begin
        expected_d = expected_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        last_bad_d = last_bad_q;
        if (check_en) begin
            unique case (state_q)
                SEEK: begin
                    if (!parity_err_in) begin
                        expected_d = nxt(mode, data_in, pattern);
                        good_run_d = 8'd1;
                    end
                end
                ACQUIRE: begin
                    expected_d = nxt(mode, data_in, pattern);
                    if (match) begin
                        good_run_d = good_run_q + 8'd1;
                        if (good_run_q + 8'd1 == LOCK_N) bad_run_d = 8'd0;
                    end else begin
                        good_run_d = 8'd1;
                    end
                end
                LOCKED: begin
                    expected_d = nxt(mode, expected_q, pattern);
                    if (match) begin
                        bad_run_d = 8'd0;
                    end else begin
                        bad_run_d  = bad_run_q + 8'd1;
                        last_bad_d = data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        word_count_d   = word_count_q;
        error_count_d  = error_count_q;
        parity_count_d = parity_count_q;
        if (data_valid) word_count_d = sat_inc(word_count_q);
        if (data_valid && parity_err_in)
            parity_count_d = sat_inc(parity_count_q);
        if (err_evt) error_count_d = sat_inc(error_count_q);
        if (clear_counts) begin
            word_count_d   = '0;
            error_count_d  = '0;
            parity_count_d = '0;
        end
    end

    always_comb begin
        locked_d      = (state_d == LOCKED);
        error_pulse_d = err_evt;
    end

    assign locked       = locked_q;
    assign error_pulse  = error_pulse_q;
    assign word_count   = word_count_q;
    assign error_count  = error_count_q;
    assign parity_count = parity_count_q;
    assign last_bad     = last_bad_q;

endmodule

// File: tb/tb_uart_seq_checker.sv
// Directed bench for uart_seq_checker: lock, errors, unlock, parity,
// mode switch, counter saturation/clear and reset priority.
module tb_uart_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       parity_err_in;
    logic [1:0] mode;
    logic [7:0] pattern;
    logic       clear_counts;

    logic        locked, error_pulse;
    logic [15:0] word_count, error_count, parity_count;
    logic [7:0]  last_bad;

    logic        s_locked, s_error_pulse;
    logic [3:0]  s_word_count, s_error_count, s_parity_count;
    logic [7:0]  s_last_bad;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_seq_checker dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_valid(data_valid), .parity_err_in(parity_err_in),
        .mode(mode), .pattern(pattern), .clear_counts(clear_counts),
        .locked(locked), .error_pulse(error_pulse),
        .word_count(word_count), .error_count(error_count),
        .parity_count(parity_count), .last_bad(last_bad)
    );

    uart_seq_checker #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_valid(data_valid), .parity_err_in(parity_err_in),
        .mode(mode), .pattern(pattern), .clear_counts(clear_counts),
        .locked(s_locked), .error_pulse(s_error_pulse),
        .word_count(s_word_count), .error_count(s_error_count),
        .parity_count(s_parity_count), .last_bad(s_last_bad)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, so the outputs
    // already reflect the word and back-to-back calls give no idle gap.
    task automatic send(input logic [7:0] w, input logic p);
        data_in       = w;
        data_valid    = 1'b1;
        parity_err_in = p;
        @(negedge clk);
        data_valid    = 1'b0;
        parity_err_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic do_clear();
        clear_counts = 1'b1;
        idle(1);
        clear_counts = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        data_in       = '0;
        data_valid    = 1'b0;
        parity_err_in = 1'b0;
        mode          = 2'd0;
        pattern       = 8'h00;
        clear_counts  = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_locked", 32'(locked), 0);
        check("rst_err_pulse", 32'(error_pulse), 0);
        check("rst_word_cnt", 32'(word_count), 0);
        check("rst_err_cnt", 32'(error_count), 0);
        check("rst_par_cnt", 32'(parity_count), 0);
        check("rst_last_bad", 32'(last_bad), 0);

        // Increment mode lock
        send(8'h10, 0); send(8'h11, 0); send(8'h12, 0);
        check("inc_prelock", 32'(locked), 0);
        send(8'h13, 0);
        check("inc_lock", 32'(locked), 1);
        send(8'h14, 0); send(8'h15, 0);
        check("inc_word_cnt", 32'(word_count), 6);
        check("inc_err_cnt", 32'(error_count), 0);

        // Single bad word while locked
        do_reset();
        send(8'h1D, 0); send(8'h1E, 0); send(8'h1F, 0); send(8'h20, 0);
        check("b1_lock", 32'(locked), 1);
        send(8'h21, 0);
        send(8'h55, 0);
        check("b1_pulse", 32'(error_pulse), 1);
        check("b1_err_cnt", 32'(error_count), 1);
        check("b1_last_bad", 32'(last_bad), 32'h55);
        send(8'h23, 0);
        check("b1_pulse_off", 32'(error_pulse), 0);
        check("b1_err_cnt2", 32'(error_count), 1);
        check("b1_still_lock", 32'(locked), 1);

        // Four bad words unlock, four good relock
        do_clear();
        check("clr_err_cnt", 32'(error_count), 0);
        check("clr_last_bad", 32'(last_bad), 32'h55);
        send(8'h00, 0); send(8'h00, 0); send(8'hEE, 0);
        check("ul_hold", 32'(locked), 1);
        send(8'h00, 0);
        check("ul_drop", 32'(locked), 0);
        check("ul_err_cnt", 32'(error_count), 4);
        check("ul_last_bad", 32'(last_bad), 0);
        send(8'h40, 0); send(8'h41, 0); send(8'h42, 0);
        check("rl_pre", 32'(locked), 0);
        send(8'h43, 0);
        check("rl_lock", 32'(locked), 1);
        check("rl_err_cnt", 32'(error_count), 4);

        // Complement mode with a parity error during acquire
        mode = 2'd3;
        idle(1);
        check("m3_seek", 32'(locked), 0);
        do_clear();
        send(8'hA5, 0); send(8'h5A, 1); send(8'hA5, 0); send(8'h5A, 0);
        check("m3_par_cnt", 32'(parity_count), 1);
        check("m3_nolock", 32'(locked), 0);
        send(8'hA5, 0);
        check("m3_lock", 32'(locked), 1);

        // Mode switch with a strobe in the same cycle: word not checked
        mode = 2'd2;
        pattern = 8'h3C;
        send(8'h77, 0);
        check("msw_unlock", 32'(locked), 0);
        check("msw_err_cnt", 32'(error_count), 0);
        check("msw_word_cnt", 32'(word_count), 6);
        send(8'h3C, 0); send(8'h3C, 0); send(8'h3C, 0);
        check("m2_pre", 32'(locked), 0);
        send(8'h3C, 0);
        check("m2_lock", 32'(locked), 1);

        mode = 2'd1;
        idle(1);
        send(8'h05, 0); send(8'h04, 0); send(8'h03, 0); send(8'h02, 0);
        check("m1_lock", 32'(locked), 1);
        send(8'h01, 0);
        check("m1_nopulse", 32'(error_pulse), 0);

        // Saturation on the 4-bit instance, then clear beats increment
        do_clear();
        for (int i = 0; i < 20; i++) send(8'(i), 0);
        check("sat_small", 32'(s_word_count), 15);
        check("sat_big", 32'(word_count), 20);
        clear_counts = 1'b1;
        send(8'h99, 1);
        clear_counts = 1'b0;
        check("clr_win_small", 32'(s_word_count), 0);
        check("clr_win_big", 32'(word_count), 0);
        check("clr_win_par", 32'(parity_count), 0);

        // Reset mid-acquire with a strobe present
        mode = 2'd0;
        do_reset();
        send(8'h10, 0); send(8'h55, 0);
        reset = 1'b1;
        send(8'h56, 1);
        reset = 1'b0;
        check("r2_locked", 32'(locked), 0);
        check("r2_pulse", 32'(error_pulse), 0);
        check("r2_word_cnt", 32'(word_count), 0);
        check("r2_err_cnt", 32'(error_count), 0);
        check("r2_par_cnt", 32'(parity_count), 0);
        check("r2_last_bad", 32'(last_bad), 0);
        send(8'h57, 0); send(8'h58, 0); send(8'h59, 0);
        check("r2_seek_pre", 32'(locked), 0);
        send(8'h5A, 0);
        check("r2_relock", 32'(locked), 1);
        check("r2_word_cnt2", 32'(word_count), 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_seq_checker.md
UART_SEQ_CHECKER -- requirements
Module: uart_seq_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning received word width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of every statistics counter.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive matching words needed to lock (legal range 2..255).
REQ-004 SHALL have parameter UNLOCK_COUNT, default 4, meaning consecutive bad words that drop lock (legal range 1..255).
REQ-005 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH, received word, valid only when data_valid=1.
REQ-008 SHALL have port data_valid, input, 1, single-cycle strobe per received word (receiver done pulse).
REQ-009 SHALL have port parity_err_in, input, 1, parity flag qualified by data_valid.
REQ-010 SHALL have port mode, input, 2, pattern select: 0 increment, 1 decrement, 2 fixed, 3 complement.
REQ-011 SHALL have port pattern, input, DATA_WIDTH, fixed word used in mode 2.
REQ-012 SHALL have port clear_counts, input, 1, synchronous clear of all counters.
REQ-013 SHALL have port locked, output, 1, high while state is LOCKED.
REQ-014 SHALL have port error_pulse, output, 1, one-cycle pulse per bad word while LOCKED.
REQ-015 SHALL have port word_count, output, CNT_WIDTH, count of all data_valid strobes.
REQ-016 SHALL have port error_count, output, CNT_WIDTH, count of bad words while LOCKED.
REQ-017 SHALL have port parity_count, output, CNT_WIDTH, count of data_valid strobes with parity_err_in=1.
REQ-018 SHALL have port last_bad, output, DATA_WIDTH, most recent bad data_in while LOCKED.

Function
REQ-019 next(d) SHALL be: mode 0 d+1 mod 2^DATA_WIDTH; mode 1 d-1 mod 2^DATA_WIDTH; mode 2 pattern; mode 3 bitwise ~d.
REQ-020 States SHALL be SEEK, ACQUIRE and LOCKED, with internal registers expected (DATA_WIDTH), good_run and bad_run (8 bits each).
REQ-021 SEEK, data_valid with no parity error: expected<=next(data_in), good_run<=1, go to ACQUIRE; a word with a parity error is ignored apart from counters.
REQ-022 ACQUIRE, match (data_in==expected, no parity error): expected<=next(data_in), good_run++; go to LOCKED, bad_run<=0, when good_run+1==LOCK_COUNT.
REQ-023 ACQUIRE, mismatch or parity error: reseed expected<=next(data_in), good_run<=1, stay in ACQUIRE.
REQ-024 LOCKED, match: expected<=next(expected), bad_run<=0.
REQ-025 LOCKED, mismatch or parity error: error_pulse=1 for one cycle, error_count++, last_bad<=data_in, expected<=next(expected) with no resync, bad_run++.
REQ-026 LOCKED: when bad_run+1==UNLOCK_COUNT on a bad word, SHALL go to SEEK with that bad word still counted.
REQ-027 A mode value differing from the value registered on the previous cycle SHALL force SEEK on the next cycle, and any data_valid in that same cycle is ignored for pattern checking.
REQ-028 All outputs SHALL be registered; counters, error_pulse, last_bad and locked update on the clock edge that samples data_valid (visible 1 cycle later).
REQ-029 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-030 clear_counts SHALL zero word_count, error_count and parity_count only, leaving state, expected and last_bad untouched; when asserted together with an increment, clear wins.
REQ-031 data_valid asserted on consecutive cycles SHALL process each word with no throughput loss.

Reset
REQ-032 reset=1 SHALL set state SEEK, locked=0, error_pulse=0, all counters=0, last_bad=0, expected=0, good_run=0, bad_run=0, registered mode=0.
REQ-033 reset SHALL take priority over every input, including a data_valid in the same cycle, and SHALL abort any operation in progress.

Verification
REQ-034 mode=0, words 0x10..0x15 sent: locked rises 1 cycle after the 0x13 strobe (LOCK_COUNT=4); word_count=6, error_count=0.
REQ-035 Locked on mode 0 at 0x20, then words 0x21, 0x55, 0x23: one error_pulse, error_count=1, last_bad=0x55, locked stays 1.
REQ-036 Locked, then 4 consecutive wrong words: error_count=4, locked falls after the 4th; the next 4 good words relock.
REQ-037 mode=3, words 0xA5, 0x5A, 0xA5, 0x5A with the 2nd carrying parity_err_in=1: parity_count=1, ACQUIRE reseeds, no lock until 4 clean matches.
REQ-038 CNT_WIDTH=4, 20 valid strobes: word_count holds at 15; clear_counts in the same cycle as a strobe leaves word_count=0.
REQ-039 reset asserted mid-ACQUIRE together with data_valid: all outputs 0 next cycle, state SEEK.
